// File: rtl/wb_picomem_slave.sv
// Wishbone pipelined responder onto a valid/ready native memory port, one transaction at a time.
// Ack arrives the cycle after i_mem_ready is sampled; stall is held for the whole BUSY/DRAIN period.
module wb_picomem_slave #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          OPT_TIMEOUT    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_wb_err,
  output logic        o_mem_valid,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] timer;
  logic        expire;

  assign expire     = OPT_TIMEOUT && (timer == TIMER_LAST);
  assign o_wb_stall = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      timer       <= 16'd0;
      o_mem_valid <= 1'b0;
      o_mem_addr  <= 32'd0;
      o_mem_wdata <= 32'd0;
      o_mem_wstrb <= 4'd0;
      o_wb_ack    <= 1'b0;
      o_wb_err    <= 1'b0;
      o_wb_data   <= 32'd0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            o_mem_addr  <= i_wb_addr;
            o_mem_wdata <= i_wb_data;
            o_mem_wstrb <= i_wb_we ? i_wb_sel : 4'h0;
            o_mem_valid <= 1'b1;
            timer       <= 16'd0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          // ready beats a coincident timeout; a dropped cyc suppresses the response
          if (i_mem_ready) begin
            o_mem_valid <= 1'b0;
            o_wb_ack    <= i_wb_cyc;
            o_wb_data   <= i_mem_rdata;
            state       <= IDLE;
          end else if (expire) begin
            o_mem_valid <= 1'b0;
            o_wb_err    <= i_wb_cyc;
            state       <= IDLE;
          end else begin
            if (OPT_TIMEOUT) timer <= timer + 16'd1;
            if (!i_wb_cyc) state <= DRAIN;
          end
        end
        DRAIN: begin
          // master has walked away: finish the native beat silently
          if (i_mem_ready || expire) begin
            o_mem_valid <= 1'b0;
            state       <= IDLE;
          end else if (OPT_TIMEOUT) begin
            timer <= timer + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_picomem_slave.sv
// Directed bench for wb_picomem_slave: per-cycle vector table plus timeout/abort/race/reset sequences.
module tb_wb_picomem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we, rdy;
  logic [31:0] addr, wdat, rdata;
  logic [3:0]  sel;
  logic        stall, ack, err, mvld;
  logic [31:0] wb_dat, maddr, mwdat;
  logic [3:0]  mwstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_picomem_slave #(.TIMEOUT_CYCLES(8), .OPT_TIMEOUT(1'b1)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdat), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(wb_dat), .o_wb_err(err),
    .o_mem_valid(mvld), .o_mem_addr(maddr), .o_mem_wdata(mwdat), .o_mem_wstrb(mwstrb),
    .i_mem_ready(rdy), .i_mem_rdata(rdata)
  );

  typedef struct {
    logic        cyc, stb, we;
    logic [31:0] addr, wdat;
    logic [3:0]  sel;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_stall, e_ack, e_err, e_vld;
    logic [31:0] e_addr, e_wdat;
    logic [3:0]  e_wstrb;
    logic [31:0] e_data;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic r,
                       input logic [31:0] rd);
    cyc = c; stb = s; we = w; addr = a; wdat = d; sel = b; rdy = r; rdata = rd;
  endtask

  task automatic chk_ctl(input string tag, input logic e_stall, input logic e_ack,
                         input logic e_err, input logic e_vld);
    chk({tag, " stall"}, 32'(stall), 32'(e_stall));
    chk({tag, " ack"},   32'(ack),   32'(e_ack));
    chk({tag, " err"},   32'(err),   32'(e_err));
    chk({tag, " valid"}, 32'(mvld),  32'(e_vld));
  endtask

  initial begin
    // cyc stb we addr wdat sel rdy rdata | stall ack err vld addr wdat wstrb data
    vec[0]  = '{1,1,0,32'h104,32'h0,4'hf,0,32'h0,               0,0,0,0,32'h0,  32'h0,       4'h0,32'h0};
    vec[1]  = '{1,0,0,32'h0,  32'h0,4'h0,0,32'h0,               1,0,0,1,32'h104,32'h0,       4'h0,32'h0};
    vec[2]  = vec[1];
    vec[3]  = vec[1];
    vec[4]  = '{1,0,0,32'h0,  32'h0,4'h0,1,32'hDEADBEEF,        1,0,0,1,32'h104,32'h0,       4'h0,32'h0};
    vec[5]  = '{1,1,1,32'h200,32'h12345678,4'h3,0,32'h0,        0,1,0,0,32'h104,32'h0,       4'h0,32'hDEADBEEF};
    vec[6]  = '{1,0,0,32'h0,  32'h0,4'h0,1,32'hAAAA5555,        1,0,0,1,32'h200,32'h12345678,4'h3,32'hDEADBEEF};
    vec[7]  = '{1,1,0,32'h300,32'h0,4'hf,0,32'h0,               0,1,0,0,32'h200,32'h12345678,4'h3,32'hAAAA5555};
    vec[8]  = '{1,0,0,32'h0,  32'h0,4'h0,1,32'h0BADF00D,        1,0,0,1,32'h300,32'h0,       4'h0,32'hAAAA5555};
    vec[9]  = '{0,1,0,32'hBAD0,32'h0,4'hf,0,32'h0,              0,1,0,0,32'h300,32'h0,       4'h0,32'h0BADF00D};
    vec[10] = '{0,0,0,32'h0,  32'h0,4'h0,0,32'h0,               0,0,0,0,32'h300,32'h0,       4'h0,32'h0BADF00D};
    vec[11] = '{0,1,1,32'hBEEF,32'h0,4'hf,1,32'hFFFFFFFF,       0,0,0,0,32'h300,32'h0,       4'h0,32'h0BADF00D};
    vec[12] = '{0,0,0,32'h0,  32'h0,4'h0,0,32'h0,               0,0,0,0,32'h300,32'h0,       4'h0,32'h0BADF00D};

    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    #1;
    chk_ctl("reset", 0, 0, 0, 0);
    chk("reset addr", maddr, 32'h0);
    chk("reset wdata", mwdat, 32'h0);
    chk("reset wstrb", 32'(mwstrb), 32'h0);
    chk("reset data", wb_dat, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // read, write, accept-in-ack-cycle, stb without cyc, stray ready in IDLE
    for (int i = 0; i < 13; i++) begin
      drive(vec[i].cyc, vec[i].stb, vec[i].we, vec[i].addr, vec[i].wdat, vec[i].sel,
            vec[i].rdy, vec[i].rdata);
      #1;
      chk_ctl($sformatf("v%0d", i), vec[i].e_stall, vec[i].e_ack, vec[i].e_err, vec[i].e_vld);
      chk($sformatf("v%0d addr", i),  maddr,          vec[i].e_addr);
      chk($sformatf("v%0d wdata", i), mwdat,          vec[i].e_wdat);
      chk($sformatf("v%0d wstrb", i), 32'(mwstrb),    32'(vec[i].e_wstrb));
      chk($sformatf("v%0d data", i),  wb_dat,         vec[i].e_data);
      step();
    end

    // timeout: valid for exactly 8 cycles then a single err
    drive(1, 1, 0, 32'h400, 32'h0, 4'hf, 0, 32'h0);
    step();
    stb = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_ctl($sformatf("tmo busy%0d", k), 1, 0, 0, 1);
      step();
    end
    chk_ctl("tmo expire", 0, 0, 1, 0);
    chk("tmo data hold", wb_dat, 32'h0BADF00D);
    step();
    chk_ctl("tmo after", 0, 0, 0, 0);
    cyc = 1'b0;
    step();

    // abort: cyc drops in BUSY, new request stalled until the native beat drains
    drive(1, 1, 0, 32'h500, 32'h0, 4'hf, 0, 32'h0);
    step();
    stb = 1'b0;
    chk_ctl("abort b1", 1, 0, 0, 1);
    step();
    cyc = 1'b0;
    step();
    drive(1, 1, 0, 32'h600, 32'h0, 4'hf, 0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_ctl($sformatf("abort drain%0d", k), 1, 0, 0, 1);
      chk($sformatf("abort addr%0d", k), maddr, 32'h500);
      step();
    end
    rdy = 1'b1; rdata = 32'h11111111;
    step();
    rdy = 1'b0;
    chk_ctl("abort exit", 0, 0, 0, 0);
    chk("abort data discard", wb_dat, 32'h0BADF00D);
    step();
    stb = 1'b0; rdy = 1'b1; rdata = 32'h22222222;
    chk_ctl("abort next busy", 1, 0, 0, 1);
    chk("abort next addr", maddr, 32'h600);
    step();
    rdy = 1'b0;
    chk_ctl("abort next ack", 0, 1, 0, 0);
    chk("abort next data", wb_dat, 32'h22222222);
    step();

    // race: ready on the last timeout cycle wins
    drive(1, 1, 0, 32'h700, 32'h0, 4'hf, 0, 32'h0);
    step();
    stb = 1'b0;
    for (int k = 0; k < 7; k++) step();
    rdy = 1'b1; rdata = 32'h33333333;
    chk_ctl("race last", 1, 0, 0, 1);
    step();
    rdy = 1'b0;
    chk_ctl("race resp", 0, 1, 0, 0);
    chk("race data", wb_dat, 32'h33333333);
    step();
    chk_ctl("race after", 0, 0, 0, 0);

    // asynchronous reset in the middle of BUSY
    drive(1, 1, 1, 32'h800, 32'h44444444, 4'hf, 0, 32'h0);
    step();
    stb = 1'b0;
    chk_ctl("rst busy", 1, 0, 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_ctl("rst async", 0, 0, 0, 0);
    chk("rst addr", maddr, 32'h0);
    chk("rst wstrb", 32'(mwstrb), 32'h0);
    chk("rst data", wb_dat, 32'h0);
    cyc = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    drive(1, 1, 0, 32'h900, 32'h0, 4'hf, 0, 32'h0);
    step();
    stb = 1'b0; rdy = 1'b1; rdata = 32'h55555555;
    chk_ctl("post rst busy", 1, 0, 0, 1);
    chk("post rst addr", maddr, 32'h900);
    step();
    rdy = 1'b0;
    chk_ctl("post rst ack", 0, 1, 0, 0);
    chk("post rst data", wb_dat, 32'h55555555);
    step();
    chk_ctl("post rst idle", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_picomem_slave.md
Name: wb_picomem_slave

Overview:
Wishbone pipelined responder that bridges bus requests onto a picorv32-style native memory interface (valid/ready, wstrb, rdata). It is the mirror of the CPU-side Wishbone master. Native-bus peripherals and memories (boot ROM, scratch RAM, native-only IP) sit behind it on the shared Wishbone interconnect. It handles one transaction at a time, has a bounded response timeout, and abort-safe draining.

Parameters:
TIMEOUT_CYCLES, 255, cycles in BUSY without i_mem_ready before the bridge returns o_wb_err; legal range 1..65535.
OPT_TIMEOUT, 1, 1 enables the timeout counter; 0 removes it, and the bridge waits forever.

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_wb_cyc  input  1  Wishbone cycle
i_wb_stb  input  1  Wishbone strobe
i_wb_we  input  1  write enable
i_wb_addr  input  32  byte address
i_wb_data  input  32  write data
i_wb_sel  input  4  byte selects
o_wb_stall  output  1  request not accepted this cycle
o_wb_ack  output  1  transaction complete, one-cycle pulse
o_wb_data  output  32  read data, valid with o_wb_ack
o_wb_err  output  1  bus error (timeout), one-cycle pulse
o_mem_valid  output  1  native request valid
o_mem_addr  output  32  native address
o_mem_wdata  output  32  native write data
o_mem_wstrb  output  4  native write strobes; 0 means read
i_mem_ready  input  1  native completion
i_mem_rdata  input  32  native read data

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE.
  - o_mem_valid, o_wb_ack and o_wb_err are 0.
  - o_mem_addr, o_mem_wdata, o_mem_wstrb, o_wb_data and the timer are 0.
  - Reset mid-transaction drops o_mem_valid immediately, with no ack and no err.
- o_wb_stall is combinational: (state != IDLE).
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - Acceptance requires i_wb_cyc && i_wb_stb.
  - On acceptance, register o_mem_addr=i_wb_addr, o_mem_wdata=i_wb_data, and o_mem_wstrb = i_wb_we ? i_wb_sel : 4'h0.
  - Also set o_mem_valid<=1, timer<=0, state->BUSY.
  - i_wb_stb without i_wb_cyc is ignored.
- BUSY:
  - o_mem_valid is held high and the o_mem_* fields are stable until completion.
  - i_mem_ready is sampled at edge M: o_mem_valid<=0, o_wb_ack<=i_wb_cyc, o_wb_data<=i_mem_rdata, state->IDLE. The ack is visible in cycle M+1.
  - i_wb_cyc low in BUSY (abort) without i_mem_ready: state->DRAIN, o_mem_valid stays high.
  - Timeout (OPT_TIMEOUT): timer increments each BUSY cycle. When timer==TIMEOUT_CYCLES-1 and !i_mem_ready: o_wb_err<=i_wb_cyc, o_mem_valid<=0, state->IDLE.
- DRAIN:
  - Waits for i_mem_ready with no ack, then ->IDLE. Data is discarded.
  - The timeout also applies in DRAIN: at expiry, drop o_mem_valid and go ->IDLE with no err.
- Simultaneous events:
  - i_mem_ready and timeout in the same cycle: ready wins; ack, no err.
  - i_mem_ready and i_wb_cyc falling in the same cycle: no ack, ->IDLE.
- o_wb_ack and o_wb_err are never both high. Each lasts exactly 1 cycle.
- Throughput:
  - Minimum 2 cycles per transaction (accept, then ready same cycle as valid).
  - The ack cycle is in IDLE, so the next request is accepted in the ack cycle.
- Latency: accept at edge N; o_mem_valid high from cycle N+1; ack in the cycle after the edge that samples i_mem_ready.
- o_wb_data holds its last value when no ack. On writes it captures i_mem_rdata, which the master ignores.

Test Plan:
- Read: cyc/stb, addr=0x0000_0104, we=0; responder returns ready 3 cycles after valid with rdata=0xDEAD_BEEF -> o_mem_wstrb=0, o_mem_addr=0x104, one ack with o_wb_data=0xDEADBEEF, stall high for the 4 cycles in BUSY.
- Write: addr=0x200, data=0x1234_5678, sel=4'b0011, ready immediate -> o_mem_wstrb=4'b0011, o_mem_wdata=0x12345678, ack 2 cycles after accept; second request accepted in the ack cycle.
- Timeout: TIMEOUT_CYCLES=8, responder never ready -> o_mem_valid high for exactly 8 cycles, then o_wb_err for 1 cycle, no ack, stall drops.
- Abort: drop cyc 2 cycles into BUSY, ready 5 cycles later -> o_mem_valid held until ready, no ack/err, new request stalled until DRAIN exits.
- Race: ready asserted on the final timeout cycle -> ack, no err.
- Reset: assert i_reset_n=0 mid-BUSY (asynchronously, between edges) -> o_mem_valid, ack and err go 0 immediately; after release the first request completes normally.
